// File: rtl/commit_trace_pkg.sv
// Shared types and the record comparison rule for the commit trace checker.
package commit_trace_pkg;

    // Width of the pc/data/address fields carried in a record; the checker's
    // XLEN parameter must match this value.
    localparam int REC_XLEN = 32;

    typedef struct packed {
        logic [REC_XLEN-1:0] pc;
        logic                regWrite;
        logic [4:0]          rd;
        logic [REC_XLEN-1:0] wdata;
        logic                memRead;
        logic                memWrite;
        logic [REC_XLEN-1:0] addr;
        logic [REC_XLEN-1:0] mdata;
    } commit_rec_t;

    typedef enum logic [2:0] {
        FIELD_NONE  = 3'd0,
        FIELD_FLAGS = 3'd1,
        FIELD_PC    = 3'd2,
        FIELD_RD    = 3'd3,
        FIELD_WDATA = 3'd4,
        FIELD_ADDR  = 3'd5,
        FIELD_MDATA = 3'd6
    } mismatch_field_e;

    typedef enum logic {
        RUN  = 1'b0,
        FAIL = 1'b1
    } chk_state_e;

    // Returns the lowest-numbered failing field. Data fields are only
    // meaningful when the matching flag is set; once the flags agree the
    // expected record's flags decide which data fields are checked.
    function automatic mismatch_field_e rec_compare(input commit_rec_t actRec,
                                                    input commit_rec_t expRec);
        mismatch_field_e code;
        code = FIELD_NONE;
        if ({actRec.regWrite, actRec.memRead, actRec.memWrite} !=
            {expRec.regWrite, expRec.memRead, expRec.memWrite}) begin
            code = FIELD_FLAGS;
        end else if (actRec.pc != expRec.pc) begin
            code = FIELD_PC;
        end else if (expRec.regWrite && (actRec.rd != expRec.rd)) begin
            code = FIELD_RD;
        end else if (expRec.regWrite && (actRec.wdata != expRec.wdata)) begin
            code = FIELD_WDATA;
        end else if ((expRec.memRead || expRec.memWrite) && (actRec.addr != expRec.addr)) begin
            code = FIELD_ADDR;
        end else if (expRec.memWrite && (actRec.mdata != expRec.mdata)) begin
            code = FIELD_MDATA;
        end
        return code;
    endfunction

endpackage

// File: rtl/commit_trace_checker_fifo.sv
// Synchronous FIFO of commit records. Pointers carry one extra wrap bit so
// full and empty can be told apart. The caller must not push while full
// unless it pops in the same cycle; the pushed record then takes the freed slot.
module commit_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  commit_rec_t                  pushData,
    input  logic                         pop,
    output commit_rec_t                  head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int LVLW = $clog2(DEPTH + 1);

    commit_rec_t      mem [DEPTH];
    logic [PTRW:0]    wrPtr;
    logic [PTRW:0]    rdPtr;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[PTRW] != rdPtr[PTRW]) && (wrPtr[PTRW-1:0] == rdPtr[PTRW-1:0]);
    assign head  = mem[rdPtr[PTRW-1:0]];

    // Record storage; contents need no reset since the pointers gate validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[PTRW-1:0]] <= pushData;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + (PTRW+1)'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + (PTRW+1)'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVLW'(1);
                2'b01:   level <= level - LVLW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_checker.sv
// In-hardware commit trace checker: buffers retiring instructions and compares
// them in order against a golden expected-record stream, latching the first
// divergence and then freezing until reset.
module commit_trace_checker
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         commit_valid,
    input  logic [XLEN-1:0]              commit_pc,
    input  logic                         commit_reg_write,
    input  logic [4:0]                   commit_rd,
    input  logic [XLEN-1:0]              commit_wdata,
    input  logic                         commit_mem_read,
    input  logic                         commit_mem_write,
    input  logic [XLEN-1:0]              commit_addr,
    input  logic [XLEN-1:0]              commit_mdata,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [XLEN-1:0]              exp_pc,
    input  logic                         exp_reg_write,
    input  logic [4:0]                   exp_rd,
    input  logic [XLEN-1:0]              exp_wdata,
    input  logic                         exp_mem_read,
    input  logic                         exp_mem_write,
    input  logic [XLEN-1:0]              exp_addr,
    input  logic [XLEN-1:0]              exp_mdata,
    output logic [31:0]                  match_count,
    output logic                         mismatch,
    output logic [31:0]                  mismatch_inum,
    output logic [2:0]                   mismatch_field,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    chk_state_e       state;
    commit_rec_t      commitRec;
    commit_rec_t      expRec;
    commit_rec_t      headRec;
    mismatch_field_e  cmpCode;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             pushEn;
    logic             popEn;

    assign commitRec = '{pc: commit_pc, regWrite: commit_reg_write, rd: commit_rd,
                         wdata: commit_wdata, memRead: commit_mem_read,
                         memWrite: commit_mem_write, addr: commit_addr,
                         mdata: commit_mdata};
    assign expRec    = '{pc: exp_pc, regWrite: exp_reg_write, rd: exp_rd,
                         wdata: exp_wdata, memRead: exp_mem_read,
                         memWrite: exp_mem_write, addr: exp_addr,
                         mdata: exp_mdata};

    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    assign exp_ready = (state == RUN) && !fifoEmpty;
    assign popEn     = exp_valid && exp_ready;
    assign pushEn    = commit_valid && (state == RUN) && (!fifoFull || popEn);
    assign cmpCode   = rec_compare(headRec, expRec);

    commit_fifo #(
        .DEPTH (DEPTH)
    ) fifoInst (
        .clk      (clk),
        .rst      (rst),
        .push     (pushEn),
        .pushData (commitRec),
        .pop      (popEn),
        .head     (headRec),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .level    (fifo_level)
    );

    // Compare outcome, sticky flags and the RUN/FAIL state; FAIL holds everything until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            match_count    <= '0;
            mismatch       <= 1'b0;
            mismatch_inum  <= '0;
            mismatch_field <= FIELD_NONE;
            overflow       <= 1'b0;
        end else begin
            if (commit_valid && (state == RUN) && fifoFull && !popEn) begin
                overflow <= 1'b1;
            end
            if (popEn) begin
                if (cmpCode == FIELD_NONE) begin
                    match_count <= match_count + 32'd1;
                end else begin
                    mismatch       <= 1'b1;
                    mismatch_inum  <= match_count;
                    mismatch_field <= cmpCode;
                    state          <= FAIL;
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Self-checking bench for commit_trace_checker: directed scenarios followed by
// a randomized phase, all checked against a queue-based model of the checker.
module tb_commit_trace_checker;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    typedef struct {
        logic [31:0] pc;
        logic        regWrite;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        memRead;
        logic        memWrite;
        logic [31:0] addr;
        logic [31:0] mdata;
    } traceRec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cValid;
    logic        eValid;
    traceRec_t   cRec;
    traceRec_t   eRec;

    wire                         exp_ready;
    wire [31:0]                  match_count;
    wire                         mismatch;
    wire [31:0]                  mismatch_inum;
    wire [2:0]                   mismatch_field;
    wire                         overflow;
    wire [$clog2(DEPTH+1)-1:0]   fifo_level;

    // Model state: the queue holds exactly the commits the checker should be buffering.
    traceRec_t   mq[$];
    int          mMatch;
    int          mInum;
    int          mField;
    bit          mMismatch;
    bit          mOverflow;
    bit          mFail;

    int          totalChecks = 0;
    int          badChecks   = 0;

    // Free-running processor clock.
    always #5 clk = ~clk;

    commit_trace_checker #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_valid     (cValid),
        .commit_pc        (cRec.pc),
        .commit_reg_write (cRec.regWrite),
        .commit_rd        (cRec.rd),
        .commit_wdata     (cRec.wdata),
        .commit_mem_read  (cRec.memRead),
        .commit_mem_write (cRec.memWrite),
        .commit_addr      (cRec.addr),
        .commit_mdata     (cRec.mdata),
        .exp_valid        (eValid),
        .exp_ready        (exp_ready),
        .exp_pc           (eRec.pc),
        .exp_reg_write    (eRec.regWrite),
        .exp_rd           (eRec.rd),
        .exp_wdata        (eRec.wdata),
        .exp_mem_read     (eRec.memRead),
        .exp_mem_write    (eRec.memWrite),
        .exp_addr         (eRec.addr),
        .exp_mdata        (eRec.mdata),
        .match_count      (match_count),
        .mismatch         (mismatch),
        .mismatch_inum    (mismatch_inum),
        .mismatch_field   (mismatch_field),
        .overflow         (overflow),
        .fifo_level       (fifo_level)
    );

    function automatic traceRec_t mkRec(input logic [31:0] pc, input logic rw, input logic [4:0] rd,
                                        input logic [31:0] wdata, input logic mr, input logic mw,
                                        input logic [31:0] addr, input logic [31:0] mdata);
        traceRec_t r;
        r.pc = pc; r.regWrite = rw; r.rd = rd; r.wdata = wdata;
        r.memRead = mr; r.memWrite = mw; r.addr = addr; r.mdata = mdata;
        return r;
    endfunction

    function automatic traceRec_t randRec();
        return mkRec($urandom & 32'hFFFF_FFFC, 1'($urandom), 5'($urandom), $urandom,
                     1'($urandom), 1'($urandom), $urandom, $urandom);
    endfunction

    // Perturbs one field; whether that perturbation matters is left to the model.
    function automatic traceRec_t corruptRec(input traceRec_t r);
        traceRec_t c;
        c = r;
        case ($urandom % 6)
            0: c.regWrite = ~c.regWrite;
            1: c.pc       = c.pc ^ 32'h4;
            2: c.rd       = c.rd ^ 5'h1;
            3: c.wdata    = c.wdata ^ 32'h0100_0000;
            4: c.addr     = c.addr ^ 32'h10;
            default: c.mdata = c.mdata ^ 32'h8000_0000;
        endcase
        return c;
    endfunction

    // Field code straight from the comparison rules: flags, pc, then data
    // fields enabled by the expected record's flags.
    function automatic int modelCode(input traceRec_t a, input traceRec_t e);
        if (a.regWrite != e.regWrite || a.memRead != e.memRead || a.memWrite != e.memWrite) return 1;
        if (a.pc != e.pc) return 2;
        if (e.regWrite && a.rd != e.rd) return 3;
        if (e.regWrite && a.wdata != e.wdata) return 4;
        if ((e.memRead || e.memWrite) && a.addr != e.addr) return 5;
        if (e.memWrite && a.mdata != e.mdata) return 6;
        return 0;
    endfunction

    task automatic clearModel();
        mq.delete();
        mMatch = 0; mInum = 0; mField = 0;
        mMismatch = 0; mOverflow = 0; mFail = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ":match_count"},    64'(match_count),    64'(mMatch));
        checkOutput({where, ":mismatch"},       64'(mismatch),       64'(mMismatch));
        checkOutput({where, ":mismatch_inum"},  64'(mismatch_inum),  64'(mInum));
        checkOutput({where, ":mismatch_field"}, 64'(mismatch_field), 64'(mField));
        checkOutput({where, ":overflow"},       64'(overflow),       64'(mOverflow));
        checkOutput({where, ":fifo_level"},     64'(fifo_level),     64'(mq.size()));
    endtask

    // One clock cycle with the currently driven inputs: predict, clock, compare.
    task automatic applyStimulus(input string where);
        bit mReady, mPop, wasFail;
        int code;
        #1;
        mReady = !mFail && (mq.size() != 0);
        checkOutput({where, ":exp_ready"}, 64'(exp_ready), 64'(mReady));
        mPop    = eValid && mReady;
        wasFail = mFail;
        if (rst) begin
            clearModel();
        end else begin
            if (cValid && !wasFail && mq.size() == DEPTH && !mPop) mOverflow = 1;
            if (mPop) begin
                code = modelCode(mq[0], eRec);
                void'(mq.pop_front());
                if (code == 0) begin
                    mMatch++;
                end else begin
                    mMismatch = 1; mInum = mMatch; mField = code; mFail = 1;
                end
            end
            if (cValid && !wasFail && (mq.size() < DEPTH)) mq.push_back(cRec);
        end
        @(posedge clk);
        #1;
        checkAll(where);
    endtask

    task automatic resetDut(input string where);
        rst = 1'b1; cValid = 1'b0; eValid = 1'b0;
        @(posedge clk);
        #1;
        clearModel();
        rst = 1'b0;
        checkAll(where);
    endtask

    traceRec_t prog[4];
    traceRec_t recC;

    initial begin
        rst = 1'b1; cValid = 1'b0; eValid = 1'b0;
        cRec = mkRec(0, 0, 0, 0, 0, 0, 0, 0);
        eRec = cRec;
        clearModel();

        // Reset state: everything zero, nothing offered downstream.
        resetDut("reset");
        checkOutput("reset_exp_ready", 64'(exp_ready), 0);
        checkOutput("reset_match", 64'(match_count), 0);

        // Four-instruction program with identical expected records.
        prog[0] = mkRec(32'h0, 1, 5'd5, 32'h10, 0, 0, 0, 0);
        prog[1] = mkRec(32'h4, 0, 5'd0, 32'h0, 0, 1, 32'h100, 32'h10);
        prog[2] = mkRec(32'h8, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        prog[3] = mkRec(32'hC, 1, 5'd6, 32'h10, 1, 0, 32'h100, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cValid = (i < 4);
            cRec   = prog[i % 4];
            eValid = (mq.size() != 0);
            eRec   = eValid ? mq[0] : prog[0];
            applyStimulus("prog");
        end
        cValid = 0; eValid = 0;
        checkOutput("prog_match_count", 64'(match_count), 4);
        checkOutput("prog_mismatch", 64'(mismatch), 0);
        checkOutput("prog_level", 64'(fifo_level), 0);

        // Third record diverges in wdata.
        resetDut("wdata_reset");
        recC = mkRec(32'h8, 1, 5'd7, 32'h12, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cValid = (i < 3);
            cRec   = (i == 0) ? prog[0] : (i == 1) ? prog[1] : recC;
            eValid = (mq.size() != 0);
            eRec   = eValid ? mq[0] : prog[0];
            if (eValid && mMatch == 2) eRec.wdata = 32'h11;
            applyStimulus("wdata");
        end
        checkOutput("wdata_mismatch", 64'(mismatch), 1);
        checkOutput("wdata_inum", 64'(mismatch_inum), 2);
        checkOutput("wdata_field", 64'(mismatch_field), 4);
        for (int i = 0; i < 3; i++) begin
            cValid = 1; cRec = randRec();
            eValid = 1; eRec = randRec();
            applyStimulus("frozen");
            checkOutput("frozen_exp_ready", 64'(exp_ready), 0);
            checkOutput("frozen_match", 64'(match_count), 2);
        end

        // Flags and pc both differ: flags win.
        resetDut("flags_reset");
        cValid = 1; cRec = mkRec(32'h20, 1, 5'd3, 32'h5, 0, 0, 0, 0);
        eValid = 0;
        applyStimulus("flags_push");
        cValid = 0;
        eValid = 1; eRec = mkRec(32'h24, 0, 5'd3, 32'h5, 0, 0, 0, 0);
        applyStimulus("flags_pop");
        eValid = 0;
        checkOutput("flags_field", 64'(mismatch_field), 1);
        checkOutput("flags_inum", 64'(mismatch_inum), 0);

        // Nine commits into an eight-deep FIFO, then drain.
        resetDut("ovf_reset");
        for (int i = 0; i < 9; i++) begin
            cValid = 1; cRec = randRec();
            applyStimulus("ovf_fill");
        end
        cValid = 0;
        checkOutput("ovf_level", 64'(fifo_level), 8);
        checkOutput("ovf_flag", 64'(overflow), 1);
        for (int i = 0; i < 20 && mq.size() != 0; i++) begin
            eValid = 1; eRec = mq[0];
            applyStimulus("ovf_drain");
        end
        eValid = 0;
        checkOutput("ovf_drained_level", 64'(fifo_level), 0);
        checkOutput("ovf_match", 64'(match_count), 8);

        // Full FIFO with push and pop every cycle across pointer wrap.
        resetDut("wrap_reset");
        for (int i = 0; i < 8; i++) begin
            cValid = 1; cRec = randRec();
            applyStimulus("wrap_fill");
        end
        for (int i = 0; i < 20; i++) begin
            cValid = 1; cRec = randRec();
            eValid = 1; eRec = mq[0];
            applyStimulus("wrap_stream");
            checkOutput("wrap_level", 64'(fifo_level), 8);
            checkOutput("wrap_overflow", 64'(overflow), 0);
        end
        cValid = 0; eValid = 0;
        checkOutput("wrap_match", 64'(match_count), 20);

        // Reset out of FAIL with three entries still queued.
        resetDut("fail_reset");
        for (int i = 0; i < 4; i++) begin
            cValid = 1; cRec = randRec();
            applyStimulus("fail_fill");
        end
        cValid = 0;
        eValid = 1; eRec = mq[0]; eRec.pc = eRec.pc ^ 32'h4;
        applyStimulus("fail_pop");
        eValid = 0;
        checkOutput("fail_field", 64'(mismatch_field), 2);
        checkOutput("fail_level", 64'(fifo_level), 3);
        resetDut("fail_rst");
        checkOutput("fail_rst_level", 64'(fifo_level), 0);
        checkOutput("fail_rst_mismatch", 64'(mismatch), 0);
        checkOutput("fail_rst_field", 64'(mismatch_field), 0);
        checkOutput("fail_rst_exp_ready", 64'(exp_ready), 0);
        cValid = 1; cRec = randRec();
        applyStimulus("fresh_push");
        cValid = 0;
        eValid = 1; eRec = mq[0];
        applyStimulus("fresh_pop");
        eValid = 0;
        checkOutput("fresh_match", 64'(match_count), 1);

        // Randomized traffic with occasional divergence and resets.
        resetDut("rand_reset");
        for (int i = 0; i < 600; i++) begin
            rst    = (mFail && ($urandom % 8 == 0)) || ($urandom % 250 == 0);
            cValid = ($urandom % 4 != 0);
            cRec   = randRec();
            eValid = ($urandom % 4 != 0);
            if (mq.size() != 0) eRec = ($urandom % 40 == 0) ? corruptRec(mq[0]) : mq[0];
            else                eRec = randRec();
            applyStimulus("rand");
        end
        rst = 0; cValid = 0; eValid = 0;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
